// File: rtl/down_counter_arbiter_311.sv
// down_counter_arbiter_311
// Shares one loadable down-counter timer among NREQ requesters using
// round-robin arbitration. The winner's load value is loaded, counted down
// to zero, and a one-cycle done pulse is returned to that requester.
// All state updates happen on the falling edge of clk_311.
//
// Optional feature macro: DCA_ABORT_EN
//   defined   : the owner dropping its request in LOAD or COUNT aborts the
//               countdown (back to IDLE, no done pulse, counter holds).
//   undefined : request withdrawal is ignored once granted.
//
// Ports
//   clk_311    in   clock (state updates on negedge)
//   reset_311  in   synchronous active-low reset
//   req_311    in   [NREQ]        request levels, held until grant
//   load_311   in   [NREQ*WIDTH]  load values, requester i at [i*WIDTH +: WIDTH]
//   grant_311  out  [NREQ]        one-hot registered grant, 0 when idle
//   owner_311  out  [OWNER_W]     current grantee index, valid while busy
//   busy_311   out  high in LOAD, COUNT and DONE
//   count_311  out  [WIDTH]       current counter value
//   done_311   out  [NREQ]        one-hot one-cycle completion pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate among pending requests
// LOAD  | owner granted; capture owner's load value into the counter
// COUNT | decrement toward zero, never below it
// DONE  | done pulse to owner; release grant and advance RR pointer next

module down_counter_arbiter_311 #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int OWNER_W = 2
) (
  input  logic                    clk_311,
  input  logic                    reset_311,
  input  logic [NREQ-1:0]         req_311,
  input  logic [NREQ*WIDTH-1:0]   load_311,
  output logic [NREQ-1:0]         grant_311,
  output logic [OWNER_W-1:0]      owner_311,
  output logic                    busy_311,
  output logic [WIDTH-1:0]        count_311,
  output logic [NREQ-1:0]         done_311
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t             state;
  logic [OWNER_W-1:0] rr_ptr;
  logic [OWNER_W-1:0] pick;
  logic               pick_valid;
  logic [OWNER_W-1:0] owner_next;
  logic [WIDTH-1:0]   load_sel;
  logic               abort;

  // Scan from the highest offset down so the lowest offset from rr_ptr
  // (the first set bit at or above the pointer, wrapping) wins.
  always_comb begin
    int idx;
    pick       = '0;
    pick_valid = 1'b0;
    idx        = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_311[idx]) begin
        pick       = OWNER_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  assign owner_next = (int'(owner_311) == NREQ - 1) ? '0 : owner_311 + OWNER_W'(1);
  assign load_sel   = load_311[int'(owner_311)*WIDTH +: WIDTH];

`ifdef DCA_ABORT_EN
  assign abort = ~req_311[owner_311];
`else
  assign abort = 1'b0;
`endif

  always_ff @(negedge clk_311) begin
    if (!reset_311) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_311 <= '0;
      owner_311 <= '0;
      busy_311  <= 1'b0;
      count_311 <= '0;
      done_311  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_311 <= NREQ'(1) << pick;
            owner_311 <= pick;
            busy_311  <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (abort) begin
            grant_311 <= '0;
            busy_311  <= 1'b0;
            rr_ptr    <= owner_next;
            state     <= IDLE;
          end else begin
            count_311 <= load_sel;
            state     <= COUNT;
          end
        end
        COUNT: begin
          if (abort) begin
            grant_311 <= '0;
            busy_311  <= 1'b0;
            rr_ptr    <= owner_next;
            state     <= IDLE;
          end else if (count_311 == '0) begin
            done_311 <= NREQ'(1) << owner_311;
            state    <= DONE;
          end else begin
            count_311 <= count_311 - WIDTH'(1);
          end
        end
        DONE: begin
          grant_311 <= '0;
          done_311  <= '0;
          busy_311  <= 1'b0;
          rr_ptr    <= owner_next;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_arbiter_311.sv
// Testbench for down_counter_arbiter_311. The reference model tracks each
// grant as a transaction (owner, load value, edges elapsed since grant) and
// derives the expected outputs from the documented latency rules.
module tb_down_counter_arbiter_311;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int OWNER_W = 2;
`ifdef DCA_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] load = '0;
  logic [NREQ-1:0]       grant;
  logic [OWNER_W-1:0]    owner;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic [NREQ-1:0]       done;

  int checks = 0;
  int errors = 0;

  down_counter_arbiter_311 #(.NREQ(NREQ), .WIDTH(WIDTH), .OWNER_W(OWNER_W)) dut (
    .clk_311(clk), .reset_311(rst), .req_311(req), .load_311(load),
    .grant_311(grant), .owner_311(owner), .busy_311(busy),
    .count_311(count), .done_311(done)
  );

  always #5 clk = ~clk;

  // reference model state
  int         m_busy = 0, m_owner = 0, m_ptr = 0, m_el = 0, m_L = 0;
  logic [7:0] m_count = '0;
  logic [3:0] m_grant = '0, m_done = '0;

  task automatic model_edge();
    if (!rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_el = 0;
      m_count = '0; m_grant = '0; m_done = '0;
    end else if (m_busy == 0) begin
      int found;
      found = 0;
      m_done = '0;
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (m_ptr + i) % NREQ;
        if (found == 0 && req[j]) begin
          found = 1;
          m_owner = j;
        end
      end
      if (found != 0) begin
        m_busy = 1; m_el = 0;
        m_grant = 4'(1 << m_owner);
      end
    end else if (ABORT && m_el <= 1 + m_L && !req[m_owner]) begin
      m_busy = 0; m_grant = '0;
      m_ptr = (m_owner + 1) % NREQ;
    end else begin
      m_el++;
      if (m_el == 1) begin
        m_L = int'(load[m_owner*WIDTH +: WIDTH]);
        m_count = 8'(m_L);
      end else if (m_el <= 1 + m_L) begin
        m_count = 8'(m_L - (m_el - 1));
      end else if (m_el == 2 + m_L) begin
        m_done = 4'(1 << m_owner);
      end else begin
        m_busy = 0; m_grant = '0; m_done = '0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask

  // one falling edge (DUT + model), then sample at the following rising edge
  task automatic tick();
    @(negedge clk);
    model_edge();
    @(posedge clk);
  endtask

  function automatic logic [18:0] obs_vec();
    return {grant, (busy ? owner : 2'b00), busy, count, done};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {m_grant, (m_busy != 0 ? 2'(m_owner) : 2'b00), (m_busy != 0), m_count, m_done};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if ({grant, owner, busy, count, done} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {grant, owner, busy, count, done});
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
    end
    req = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    int done_at = -1, pulses = 0;
    load = {4{8'($urandom_range(0, 255))}};
    load[2*WIDTH +: WIDTH] = 8'd3;
    req = 4'b0100;
    for (int n = 1; n <= 12; n++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (n == 1) begin
        checks++;
        if (grant !== 4'b0100) begin
          errors++;
          $display("FAIL single_grant got=%b want=0100", grant);
        end
      end
      if (done !== '0) begin
        pulses++;
        if (done_at < 0) done_at = n;
        req = '0;
      end
    end
    checks++;
    if (done_at !== 6 || pulses !== 1) begin
      errors++;
      $display("FAIL single_done edge=%0d pulses=%0d want edge=6 pulses=1", done_at, pulses);
    end
  endtask

  task automatic test_round_robin();
    int owners[$];
    int dones = 0;
    logic [3:0] prev_grant;
    do_reset();
    load = '0;
    req = 4'b1111;
    prev_grant = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rr_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (prev_grant == '0 && grant != '0) owners.push_back(int'(owner));
      if (done != '0) dones++;
      prev_grant = grant;
    end
    req = '0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done != '0) dones++;
    end
    checks++;
    if (owners.size() < 8) begin
      errors++;
      $display("FAIL rr_grants got=%0d want>=8", owners.size());
    end
    for (int i = 0; i < owners.size() && i < 8; i++) begin
      checks++;
      if (owners[i] !== i % 4) begin
        errors++;
        $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, owners[i], i % 4);
      end
    end
    checks++;
    if (dones !== owners.size()) begin
      errors++;
      $display("FAIL rr_dones got=%0d want=%0d", dones, owners.size());
    end
  endtask

  task automatic test_zero_max();
    int done_at, wrapped;
    int targets[2] = '{1, 3};
    int lvals[2] = '{0, 255};
    int want[2] = '{3, 258};
    for (int t = 0; t < 2; t++) begin
      done_at = -1;
      wrapped = 0;
      load = '0;
      load[targets[t]*WIDTH +: WIDTH] = 8'(lvals[t]);
      req = 4'(1 << targets[t]);
      for (int n = 1; n <= 270 && done_at < 0; n++) begin
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL zmax_l%0d_cycle%0d got=%h want=%h", lvals[t], n, obs_vec(), exp_vec());
        end
        if (n > 2 && count == 8'hFF && lvals[t] == 255 && n != 2) wrapped = (n > 2) ? 1 : 0;
        if (done != '0) done_at = n;
      end
      req = '0;
      tick();
      tick();
      checks++;
      if (done_at !== want[t]) begin
        errors++;
        $display("FAIL zmax_done_l%0d edge=%0d want=%0d", lvals[t], done_at, want[t]);
      end
      checks++;
      if (wrapped != 0 || count !== 8'd0) begin
        errors++;
        $display("FAIL zmax_nowrap_l%0d count=%0d want=0", lvals[t], count);
      end
    end
  endtask

  task automatic test_midcount_reset();
    int seen_done = 0, reached = 0;
    load = '0;
    req = 4'b0001;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (done != '0) req = '0;
    end
    req = 4'b0100;
    load[2*WIDTH +: WIDTH] = 8'd200;
    for (int n = 0; n < 300 && reached == 0; n++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mreset_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (busy && count == 8'd100) reached = 1;
    end
    checks++;
    if (reached == 0) begin
      errors++;
      $display("FAIL mreset_reach count=%0d want=100", count);
    end
    rst = 1'b0;
    req = 4'b1101;
    tick();
    if (done != '0) seen_done = 1;
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || grant !== 4'b0000 || seen_done != 0) begin
      errors++;
      $display("FAIL mreset_clear count=%0d busy=%b grant=%b done=%b want 0", count, busy, grant, done);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++;
      $display("FAIL mreset_rearb grant=%b owner=%0d want 0001/0", grant, owner);
    end
    req = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mreset_after%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (done != '0) req = '0;
    end
  endtask

  task automatic test_abort();
    int dones = 0, hit = 0;
    load = '0;
    load[1*WIDTH +: WIDTH] = 8'd20;
    req = 4'b0010;
    for (int n = 0; n < 40 && hit == 0; n++) begin
      tick();
      if (busy && count == 8'd5) hit = 1;
    end
    req = '0;
    tick();
    checks++;
    if (busy !== (ABORT ? 1'b0 : 1'b1) || count !== (ABORT ? 8'd5 : 8'd4)) begin
      errors++;
      $display("FAIL abort_step busy=%b count=%0d want busy=%b count=%0d",
               busy, count, !ABORT, ABORT ? 5 : 4);
    end
    for (int n = 0; n < 12; n++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL abort_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (done != '0) dones++;
      tick();
    end
    checks++;
    if (dones !== (ABORT ? 0 : 1)) begin
      errors++;
      $display("FAIL abort_dones got=%0d want=%0d", dones, ABORT ? 0 : 1);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NREQ; i++)
        load[i*WIDTH +: WIDTH] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      req = req | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if (done != '0) req = req & ~done;
      if ($urandom_range(0, 29) == 0) req = req & 4'($urandom);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        bad++;
        if (bad < 10) $display("FAIL random_cycle%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
    end
    rst = 1'b1;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_max();
    test_midcount_reset();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
